// File: rtl/count_sequence_checker_pkg.sv
// Shared state encoding and default widths for the counter sequence checker.
package count_sequence_checker_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_ERR_W  = 8;
  localparam int DEF_WRAP_W = 8;

endpackage

// File: rtl/count_sequence_checker_sat_counter.sv
// Saturating up-counter: stops at all-ones, cleared by reset or clr.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/count_sequence_checker.sv
// Monitors one free-running counter: locks onto its increment sequence and
// flags illegal steps, tolerating holds, counter resets and wrap-around.
module count_sequence_checker
  import count_sequence_checker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              sample_en,
  input  logic              clear,
  output logic              locked,
  output logic              fault,
  output logic              error_pulse,
  output logic              reset_seen,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [1:0]        state
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [WIDTH-1:0]   next_val;
  logic               err_inc, wrap_inc, reset_seen_d;

  assign next_val = prev_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state_q     <= ST_UNLOCKED;
      prev_q      <= '0;
      error_pulse <= 1'b0;
      reset_seen  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      error_pulse <= err_inc;
      reset_seen  <= reset_seen_d;
    end
  end

  // Step checks in LOCKED are ordered so a max-to-0 wrap is a legal step, not a reset.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    err_inc      = 1'b0;
    wrap_inc     = 1'b0;
    reset_seen_d = 1'b0;
    if (sample_en) begin
      prev_d = count_in;
      case (state_q)
        ST_UNLOCKED: state_d = ST_LOCKING;
        ST_LOCKING: begin
          if (count_in == next_val) state_d = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (count_in == next_val) begin
            wrap_inc = (count_in == '0);
          end else if (count_in == prev_q) begin
            state_d = ST_LOCKED;
          end else if (count_in == '0) begin
            reset_seen_d = 1'b1;
            state_d      = ST_LOCKING;
          end else begin
            err_inc = 1'b1;
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (count_in == '0) begin
            reset_seen_d = 1'b1;
            state_d      = ST_LOCKING;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clear),
    .q     (err_count)
  );

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_inc),
    .clr   (clear),
    .q     (wrap_count)
  );

  assign locked = (state_q == ST_LOCKED);
  assign fault  = (state_q == ST_FAULT);
  assign state  = state_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Self-checking bench: directed test-plan sequences plus random traffic,
// compared every cycle against a behavioural model of the checking rules.
module tb_count_sequence_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] count_in = '0;
  logic       sample_en = 1'b0;
  logic       clear = 1'b0;

  logic       locked, fault, error_pulse, reset_seen;
  logic [7:0] err_count, wrap_count;
  logic [1:0] state;

  logic       s_locked, s_fault, s_error_pulse, s_reset_seen;
  logic [1:0] s_err_count;
  logic [7:0] s_wrap_count;
  logic [1:0] s_state;

  int checks = 0;
  int errors = 0;

  // Model: mode 0..3 matches the published state encoding
  int m_mode = 0, m_prev = 0, m_err = 0, m_wrap = 0;
  int m_err_pulse = 0, m_reset_seen = 0;

  always #5 clk = ~clk;

  count_sequence_checker dut (
    .clk(clk), .reset(reset), .count_in(count_in), .sample_en(sample_en),
    .clear(clear), .locked(locked), .fault(fault), .error_pulse(error_pulse),
    .reset_seen(reset_seen), .err_count(err_count), .wrap_count(wrap_count),
    .state(state)
  );

  count_sequence_checker #(.WIDTH(4), .ERR_W(2), .WRAP_W(8)) dut_small (
    .clk(clk), .reset(reset), .count_in(count_in), .sample_en(sample_en),
    .clear(clear), .locked(s_locked), .fault(s_fault), .error_pulse(s_error_pulse),
    .reset_seen(s_reset_seen), .err_count(s_err_count), .wrap_count(s_wrap_count),
    .state(s_state)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic modelStep(input logic rst_n, input logic clr, input logic en, input int val);
    int nxt;
    m_err_pulse  = 0;
    m_reset_seen = 0;
    if (!rst_n || clr) begin
      m_mode = 0; m_prev = 0; m_err = 0; m_wrap = 0;
    end else if (en) begin
      nxt = (m_prev + 1) % 16;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (val == nxt) m_mode = 2;
      end else if (m_mode == 2) begin
        if (val == nxt) begin
          if (val == 0) m_wrap++;
        end else if (val == m_prev) begin
          m_mode = 2;
        end else if (val == 0) begin
          m_reset_seen = 1; m_mode = 1;
        end else begin
          m_err_pulse = 1; m_err++; m_mode = 3;
        end
      end else if (val == 0) begin
        m_reset_seen = 1; m_mode = 1;
      end
      m_prev = val;
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic clr, input logic en, input int val);
    @(negedge clk);
    reset     = rst_n;
    clear     = clr;
    sample_en = en;
    count_in  = 4'(val);
    @(posedge clk);
    modelStep(rst_n, clr, en, val);
    #1;
    checkOutput("state",       int'(state),       m_mode);
    checkOutput("locked",      int'(locked),      int'(m_mode == 2));
    checkOutput("fault",       int'(fault),       int'(m_mode == 3));
    checkOutput("error_pulse", int'(error_pulse), m_err_pulse);
    checkOutput("reset_seen",  int'(reset_seen),  m_reset_seen);
    checkOutput("err_count",   int'(err_count),   sat(m_err, 255));
    checkOutput("wrap_count",  int'(wrap_count),  sat(m_wrap, 255));
    checkOutput("sat_err_count", int'(s_err_count), sat(m_err, 3));
    checkOutput("sat_state",   int'(s_state),     m_mode);
  endtask

  task automatic sample(input int val);
    applyStimulus(1'b1, 1'b0, 1'b1, val);
  endtask

  initial begin
    int r, v;
    // Lock and wrap
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 16; i++) sample(i);
    sample(0);
    sample(1);
    checkOutput("lock_wrap_count", int'(wrap_count), 1);
    // Holds
    sample(2); sample(3); sample(3); sample(4); sample(4); sample(5);
    checkOutput("holds_locked", int'(locked), 1);
    // Illegal jump, no further errors in FAULT, then resync
    sample(6); sample(7); sample(9);
    checkOutput("jump_err_count", int'(err_count), 1);
    sample(10); sample(11); sample(0); sample(1);
    // Counter reset mid-run
    for (int i = 2; i <= 9; i++) sample(i);
    sample(0); sample(1);
    // Reset / clear priority, idle cycles
    sample(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 7);
    for (int i = 0; i < 4; i++) sample(i);
    applyStimulus(1'b1, 1'b1, 1'b1, 9);
    sample(0); sample(1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 12);
    // Saturation: repeated fault/resync cycles
    for (int i = 0; i < 5; i++) begin
      sample(2); sample(5); sample(0); sample(1);
    end
    checkOutput("sat_err_stop", int'(s_err_count), 3);
    checkOutput("full_err_count", int'(err_count), 5);
    // Random traffic biased toward legal steps
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50)      v = (m_prev + 1) % 16;
      else if (r < 70) v = m_prev;
      else if (r < 80) v = 0;
      else             v = int'($urandom_range(0, 15));
      r = int'($urandom_range(0, 99));
      if (r < 2)       applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), v);
      else if (r < 4)  applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), v);
      else if (r < 18) applyStimulus(1'b1, 1'b0, 1'b0, v);
      else             sample(v);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sequence_checker.md
Name: count_sequence_checker

Overview:
- Downstream monitor for the 4-bit free-running counters; consumes one counter's output value.
- Locks onto the incrementing sequence, then flags any illegal step. Tolerates holds, counter resets and wrap-around.
- Counts errors and wraps.
- One instance per counter in the counter test harness; outputs feed pass/fail logic and the waveform trace.

Parameters:
- WIDTH, 4, width of the monitored count value.
- ERR_W, 8, width of the saturating error counter.
- WRAP_W, 8, width of the saturating wrap counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- count_in  input  WIDTH  counter value under observation.
- sample_en  input  1  qualifies count_in for the current cycle; when low, the cycle is ignored.
- clear  input  1  synchronous soft clear; same effect as reset.
- locked  output  1  high while in the LOCKED state.
- fault  output  1  high while in the FAULT state.
- error_pulse  output  1  one-cycle strobe marking a detected illegal step.
- reset_seen  output  1  one-cycle strobe marking a detected counter reset.
- err_count  output  ERR_W  number of errors; saturates at all-ones.
- wrap_count  output  WRAP_W  number of legal max-to-0 wraps; saturates at all-ones.
- state  output  2  encoded FSM state, for debug.

Behaviour:
- Reset and clear:
  - reset low, or clear high, at a rising edge: state=UNLOCKED, prev=0, and every output goes to 0.
  - Both take priority over sample_en; the sample in that cycle is discarded.
- Timing:
  - All outputs are registered.
  - A sample at edge N is reflected on the outputs after edge N.
  - Strobes are high for exactly one cycle.
- Idle cycles: with sample_en low, state and counters hold and the strobes are 0.
- Terms used below: next = (prev+1) mod 2^WIDTH. prev is updated to count_in on every accepted sample.
- State UNLOCKED (0): a sample captures prev and moves to LOCKING.
- State LOCKING (1):
  - count_in==next -> LOCKED.
  - count_in==prev -> stay (hold).
  - Otherwise -> stay, with no error.
- State LOCKED (2), checks in priority order:
  1. count_in==next: legal step. If count_in==0, this is a wrap and wrap_count increments.
  2. count_in==prev: legal hold, no action.
  3. count_in==0: counter reset. Pulse reset_seen and go to LOCKING. No error is raised.
  4. Anything else: pulse error_pulse, increment err_count, go to FAULT.
- State FAULT (3):
  - Samples do not raise further errors.
  - count_in==0 -> reset_seen pulse, go to LOCKING.
  - Otherwise stay.
  - fault stays high until a resync or a clear.
- Edge cases:
  - Wrap from max to 0 while in LOCKED: handled by rule 1 (legal step), never by rule 3.
  - Hold at 0 after a counter reset: handled as a hold.
- Saturation: err_count and wrap_count stop at 2^ERR_W-1 and 2^WRAP_W-1 respectively, with no rollover.
- Input handling: no metastability handling; count_in is synchronous to clk.

Decomposition:
- Shared package:
  - state encoding constants: ST_UNLOCKED=0, ST_LOCKING=1, ST_LOCKED=2, ST_FAULT=3.
  - default widths: 4, 8, 8.
- Sub-module sat_counter, parameterised width, with ports inc, clr and q.
  - Instantiated twice: once for err_count, once for wrap_count.
- Everything else is a single FSM plus the prev register.

Test Plan:
- Lock and wrap:
  - Stimulus: reset low for 2 cycles, then count_in 0,1,...,15,0,1 with sample_en=1 every cycle.
  - Required: locked=1 after the 2nd sample; wrap_count=1; err_count=0; error_pulse never high.
- Holds:
  - Stimulus: once locked, sequence 3,3,4,4,5 (a counter that changes every other cycle).
  - Required: locked stays 1; no error_pulse.
- Illegal jump:
  - Stimulus: once locked, sequence 6,7,9.
  - Required: error_pulse high for 1 cycle after the edge that samples 9; err_count=1; fault=1; state=3.
  - Follow-up stimulus: 10,11 -> no further errors.
  - Follow-up stimulus: 0 -> reset_seen pulse; state=1.
  - Follow-up stimulus: 1 -> locked=1.
- Counter reset mid-run:
  - Stimulus: once locked at 9, drive 0.
  - Required: reset_seen pulse; err_count unchanged; state LOCKING.
  - Follow-up stimulus: 1 -> LOCKED.
- Reset and clear priority:
  - Stimulus 1: reset low at the same edge as an illegal sample. Required: all outputs 0; state=0; no error_pulse.
  - Stimulus 2: clear=1 with sample_en=1. Required: same result.
  - Stimulus 3: sample_en=0 for 5 cycles. Required: state unchanged.
- Saturation:
  - Stimulus: ERR_W=2; force 5 fault/resync cycles.
  - Required: err_count stops at 3.
